// File: rtl/pong_display_pkg.sv
// pong_display_pkg: glyph geometry, converter states and the 4x9 digit glyph table
package pong_display_pkg;
   localparam int GLYPH_W     = 4;
   localparam int GLYPH_H     = 9;
   localparam int DIGIT_PITCH = 5;
   localparam int MAX_SCALE   = 5;
   localparam logic [8:0] BLANK_GLYPH = 9'h000;
   typedef enum logic [1:0] {CONV_IDLE, CONV_SHIFT, CONV_COMMIT} conv_state_t;
   localparam logic [9:0][8:0] GLYPH_L = {9'h11F, 9'h1FF, 9'h001, 9'h1FF, 9'h11F,
                                          9'h01F, 9'h111, 9'h1F1, 9'h000, 9'h1FF};
   localparam logic [9:0][8:0] GLYPH_M = {9'h111, 9'h111, 9'h001, 9'h111, 9'h111,
                                          9'h010, 9'h111, 9'h111, 9'h000, 9'h101};
   localparam logic [9:0][8:0] GLYPH_R = {9'h1FF, 9'h1FF, 9'h1FF, 9'h1F1, 9'h1F1,
                                          9'h1FF, 9'h1FF, 9'h11F, 9'h1FF, 9'h1FF};
   function automatic logic [8:0] glyph_col(input logic [3:0] digit, input logic [1:0] col);
      if (digit > 4'd9) return BLANK_GLYPH;
      return (col == 2'd0) ? GLYPH_L[digit] : (col == 2'd3) ? GLYPH_R[digit] : GLYPH_M[digit];
   endfunction
   function automatic int pow10(input int n);
      int r;
      r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 binary to BCD converter with saturation flag
module bin2bcd_seq
   import pong_display_pkg::*;
#(
   parameter int VALUE_W    = 10,
   parameter int NUM_DIGITS = 3
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_start,
   input  logic [VALUE_W-1:0]         i_value,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_sat,
   output logic [NUM_DIGITS-1:0][3:0] o_bcd
);
   localparam int CNT_W = $clog2(VALUE_W + 1);
   localparam int BCD_W = 4 * NUM_DIGITS;
   localparam logic [32:0] MAX_VAL = 33'(pow10(NUM_DIGITS) - 1);
   conv_state_t r_state, w_next;
   logic [VALUE_W-1:0]         r_bin;
   logic [NUM_DIGITS-1:0][3:0] r_bcd, w_adj;
   logic [CNT_W-1:0]           r_cnt;
   logic                       r_sat, w_load;
   assign o_sat = r_sat;
   assign o_bcd = r_bcd;
   // state register
   always_ff @(posedge clk or negedge reset)
      if (!reset) r_state <= CONV_IDLE;
      else r_state <= w_next;
   // next state; a start in COMMIT chains straight into the next conversion
   always_comb begin
      w_next = r_state;
      o_busy = 1'b1;
      o_done = 1'b0;
      w_load = 1'b0;
      case (r_state)
         CONV_IDLE: begin
            o_busy = 1'b0;
            w_load = i_start;
            w_next = i_start ? CONV_SHIFT : CONV_IDLE;
         end
         CONV_SHIFT: w_next = (r_cnt == '0) ? CONV_COMMIT : CONV_SHIFT;
         CONV_COMMIT: begin
            o_done = 1'b1;
            w_load = i_start;
            w_next = i_start ? CONV_SHIFT : CONV_IDLE;
         end
         default: w_next = CONV_IDLE;
      endcase
   end
   // add 3 to every BCD digit of 5 or more ahead of the shift
   always_comb
      for (int i = 0; i < NUM_DIGITS; i++)
         w_adj[i] = (r_bcd[i] >= 4'd5) ? r_bcd[i] + 4'd3 : r_bcd[i];
   // capture a new value or perform one shift step
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_bin <= '0;
         r_bcd <= '0;
         r_cnt <= '0;
         r_sat <= 1'b0;
      end else if (w_load) begin
         r_bin <= i_value;
         r_bcd <= '0;
         r_cnt <= CNT_W'(VALUE_W - 1);
         r_sat <= 33'(i_value) > MAX_VAL;
      end else if (r_state == CONV_SHIFT) begin
         r_bin <= r_bin << 1;
         r_bcd <= BCD_W'({w_adj, r_bin[VALUE_W-1]});
         r_cnt <= r_cnt - CNT_W'(1);
      end
endmodule

// File: rtl/score_display.sv
// score_display: multi-digit decimal score renderer answering VGA pixel polls
// Optional feature macro SCORE_BLINK_EN: free-running blink counter gating Hit when Blink=1.
module score_display
   import pong_display_pkg::*;
#(
   parameter int NUM_DIGITS = 3,
   parameter int VALUE_W    = 10,
   parameter int BLINK_DIV  = 24
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [10:0]        ObjectX,
   input  logic [9:0]         ObjectY,
   input  logic [3:0]         ObjectScale,
   input  logic [VALUE_W-1:0] Value,
   input  logic               ValueLoad,
   input  logic               LeadZeroBlank,
   input  logic               Blink,
   input  logic [9:0]         PollX,
   input  logic [8:0]         PollY,
   output logic               Busy,
   output logic               Hit,
   output logic               Hit2
);
   logic                       w_start, w_accept, w_done, w_sat, w_in, w_gate;
   logic                       r_pend_v, r_in, w_lz, w_blank, w_lit;
   logic [VALUE_W-1:0]         r_pend_val;
   logic [NUM_DIGITS-1:0][3:0] w_bcd, r_digits;
   logic [2:0]                 w_s, w_pos, w_gcol;
   logic [11:0]                w_dx, w_dy, w_w, w_h;
   logic [4:0]                 w_col, r_col;
   logic [3:0]                 w_row, r_row, w_dig;
   logic [8:0]                 w_glyph;
   assign w_start  = ValueLoad || r_pend_v;
   assign w_accept = w_start && (!Busy || w_done);
   bin2bcd_seq #(.VALUE_W(VALUE_W), .NUM_DIGITS(NUM_DIGITS)) u_conv (
      .clk     (clk),
      .reset   (reset),
      .i_start (w_start),
      .i_value (ValueLoad ? Value : r_pend_val),
      .o_busy  (Busy),
      .o_done  (w_done),
      .o_sat   (w_sat),
      .o_bcd   (w_bcd)
   );
   // one-deep pending load, latest value wins until the converter accepts it
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_pend_v   <= 1'b0;
         r_pend_val <= '0;
      end else if (w_accept) r_pend_v <= 1'b0;
      else if (ValueLoad) begin
         r_pend_v   <= 1'b1;
         r_pend_val <= Value;
      end
   // committed digit bank, updated only when a conversion completes
   always_ff @(posedge clk or negedge reset)
      if (!reset) r_digits <= '0;
      else if (w_done) r_digits <= w_sat ? {NUM_DIGITS{4'd9}} : w_bcd;
   assign w_s   = (ObjectScale > 4'(MAX_SCALE)) ? 3'(MAX_SCALE) : ObjectScale[2:0];
   assign w_dx  = {2'b0, PollX} - {1'b0, ObjectX};
   assign w_dy  = {3'b0, PollY} - {2'b0, ObjectY};
   assign w_w   = 12'(DIGIT_PITCH * (NUM_DIGITS - 1) + GLYPH_W) << w_s;
   assign w_h   = 12'(GLYPH_H) << w_s;
   assign w_in  = !w_dx[11] && !w_dy[11] && (w_dx < w_w) && (w_dy < w_h);
   assign w_col = 5'(w_dx >> w_s);
   assign w_row = 4'(w_dy >> w_s);
   // stage 2: pick digit and glyph column, apply leading-zero blanking, fetch the bit
   always_comb begin
      w_pos = '0;
      for (int i = 1; i < NUM_DIGITS; i++)
         if (r_col >= 5'(DIGIT_PITCH * i)) w_pos = 3'(i);
      w_gcol  = 3'(r_col - 5'(w_pos) * 5'(DIGIT_PITCH));
      w_lz    = LeadZeroBlank;
      w_dig   = '0;
      w_blank = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         w_lz = w_lz && (r_digits[NUM_DIGITS-1-i] == 4'd0) && (i != NUM_DIGITS - 1);
         if (3'(i) == w_pos) begin
            w_dig   = r_digits[NUM_DIGITS-1-i];
            w_blank = w_lz;
         end
      end
      w_glyph = glyph_col(w_blank ? 4'hF : w_dig, w_gcol[1:0]);
      w_lit   = r_in && (w_gcol != 3'd4) && w_glyph[r_row];
   end
`ifdef SCORE_BLINK_EN
   logic [BLINK_DIV:0] r_blink;
   // free-running blink phase counter; its MSB selects the dark half-period
   always_ff @(posedge clk or negedge reset)
      if (!reset) r_blink <= '0;
      else r_blink <= r_blink + {{BLINK_DIV{1'b0}}, 1'b1};
   assign w_gate = Blink && r_blink[BLINK_DIV];
`else
   logic w_unused;
   assign w_unused = Blink | (BLINK_DIV == 0);
   assign w_gate   = 1'b0;
`endif
   // poll pipeline: stage 1 offsets and bounds, stage 2 registered hit flags
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_in  <= 1'b0;
         r_col <= '0;
         r_row <= '0;
         Hit   <= 1'b0;
         Hit2  <= 1'b0;
      end else begin
         r_in  <= w_in;
         r_col <= w_col;
         r_row <= w_row;
         Hit   <= w_lit && !w_gate;
         Hit2  <= r_in;
      end
endmodule

// File: tb/tb_score_display.sv
`timescale 1ns/1ps
module tb_score_display;
   localparam int N  = 3;
   localparam int VW = 10;
   logic clk = 0, reset = 0;
   logic [10:0] ObjectX = 0;
   logic [9:0]  ObjectY = 0;
   logic [3:0]  ObjectScale = 0;
   logic [VW-1:0] Value = 0;
   logic ValueLoad = 0, LeadZeroBlank = 0, Blink = 0;
   logic [9:0] PollX = 0;
   logic [8:0] PollY = 0;
   logic Busy, Hit, Hit2;
   always #5 clk = ~clk;
   score_display #(.NUM_DIGITS(N), .VALUE_W(VW), .BLINK_DIV(4)) dut (
      .clk(clk), .reset(reset), .ObjectX(ObjectX), .ObjectY(ObjectY),
      .ObjectScale(ObjectScale), .Value(Value), .ValueLoad(ValueLoad),
      .LeadZeroBlank(LeadZeroBlank), .Blink(Blink), .PollX(PollX), .PollY(PollY),
      .Busy(Busy), .Hit(Hit), .Hit2(Hit2)
   );
   int n_chk = 0, n_fail = 0, busy_cyc = 0;
   bit chk_en = 0;
   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   // seven-segment patterns {a,b,c,d,e,f,g}
   int seg [10] = '{'h7E, 'h30, 'h6D, 'h79, 'h33, 'h5B, 'h5F, 'h70, 'h7F, 'h7B};
   function automatic int p10(input int n);
      int r;
      r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction
   function automatic bit lit(input int shown, input int col, input int row, input bit lzb);
      int p, g, w, sg;
      p = col / 5;
      g = col % 5;
      if (g == 4) return 0;
      w = p10(N - 1 - p);
      if (lzb && p < N - 1 && shown < w) return 0;
      sg = seg[(shown / w) % 10];
      return (sg[6] && row == 0) || (sg[0] && row == 4) || (sg[3] && row == 8) ||
             (g == 0 && ((sg[1] && row <= 4) || (sg[2] && row >= 4))) ||
             (g == 3 && ((sg[5] && row <= 4) || (sg[4] && row >= 4)));
   endfunction
   int m_shown, m_cur, m_pend, m_finish, m_cyc, m_ticks, m1_col, m1_row, ms, mdx, mdy;
   bit m_busy, m_pend_v, m1_in, m_hit, m_hit2, mgate;
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_shown = 0; m_busy = 0; m_pend_v = 0; m1_in = 0; m_hit = 0; m_hit2 = 0;
         m_cyc = 0; m_ticks = 0;
      end else begin
         mgate = 0;
`ifdef SCORE_BLINK_EN
         mgate = Blink && ((m_ticks / 16) % 2 == 1);
`endif
         m_hit2 = m1_in;
         m_hit  = m1_in && lit(m_shown, m1_col, m1_row, LeadZeroBlank) && !mgate;
         ms  = ObjectScale > 5 ? 5 : int'(ObjectScale);
         mdx = int'(PollX) - int'(ObjectX);
         mdy = int'(PollY) - int'(ObjectY);
         m1_in  = mdx >= 0 && mdx < (5 * N - 1) * (1 << ms) && mdy >= 0 && mdy < 9 * (1 << ms);
         m1_col = m1_in ? mdx / (1 << ms) : 0;
         m1_row = m1_in ? mdy / (1 << ms) : 0;
         m_cyc++;
         if (m_busy && m_cyc == m_finish) begin
            m_shown = m_cur > p10(N) - 1 ? p10(N) - 1 : m_cur;
            if (ValueLoad || m_pend_v) begin
               m_cur = ValueLoad ? int'(Value) : m_pend;
               m_finish = m_cyc + VW + 1;
               m_pend_v = 0;
            end else m_busy = 0;
         end else if (m_busy && ValueLoad) begin
            m_pend = Value;
            m_pend_v = 1;
         end else if (ValueLoad) begin
            m_busy = 1;
            m_cur = Value;
            m_finish = m_cyc + VW + 1;
         end
         m_ticks++;
      end
   end
   always @(negedge clk) begin
      if (Busy) busy_cyc++;
      if (chk_en) begin
         check("busy_vs_model", Busy, m_busy);
         check("hit_vs_model", Hit, m_hit);
         check("hit2_vs_model", Hit2, m_hit2);
      end
   end
   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic load(input int v);
      Value = VW'(v);
      ValueLoad = 1;
      tick();
      ValueLoad = 0;
   endtask
   task automatic poll(input int x, input int y);
      PollX = 10'(x);
      PollY = 9'(y);
      tick(2);
   endtask
   task automatic wait_idle();
      int t;
      t = 0;
      while (Busy && t < 200) begin
         tick();
         t++;
      end
      check("busy_bound", int'(t < 200), 1);
   endtask
   int t0, run;
   logic prev;
   initial begin
      tick();
      chk_en = 1;
      check("rst_busy", Busy, 0);
      check("rst_hit2", Hit2, 0);
      reset = 1;
      ObjectX = 100; ObjectY = 50; ObjectScale = 1;
      poll(100, 50);  check("origin_hit", Hit, 1); check("origin_hit2", Hit2, 1);
      poll(108, 50);  check("gap_hit", Hit, 0);    check("gap_hit2", Hit2, 1);
      poll(99, 50);   check("left_hit", Hit, 0);   check("left_hit2", Hit2, 0);
      busy_cyc = 0;
      load(537);
      wait_idle();
      check("busy_len_537", busy_cyc, 11);
      poll(102, 50);  check("d5_c1_r0", Hit, 1);
      poll(102, 52);  check("d5_c1_r1", Hit, 0);
      poll(110, 58);  check("d3_c0_r4", Hit, 1);
      poll(110, 54);  check("d3_c0_r2", Hit, 0);
      poll(126, 66);  check("d7_c3_r8", Hit, 1);
      poll(100, 50);
      load(537);
      tick(3);
      reset = 0;
      #1;
      check("rst_mid_busy", Busy, 0);
      check("rst_mid_hit", Hit, 0);
      tick();
      reset = 1;
      tick();
      poll(100, 62);  check("after_rst_digit0", Hit, 1);
      busy_cyc = 0;
      load(12);
      tick(3);
      load(999);
      tick(8);
      poll(120, 62);  check("mid_012", Hit, 1);
      wait_idle();
      check("busy_len_chain", busy_cyc, 22);
      poll(120, 62);  check("final_999_c0", Hit, 0);
      poll(102, 58);  check("final_999_c1", Hit, 1);
      load(1000);
      wait_idle();
      poll(110, 58);  check("sat_999", Hit, 1);
      LeadZeroBlank = 1;
      load(7);
      wait_idle();
      poll(100, 50);  check("lzb_d0_hit", Hit, 0); check("lzb_d0_hit2", Hit2, 1);
      poll(110, 50);  check("lzb_d1_hit", Hit, 0);
      poll(120, 50);  check("lzb_d2_hit", Hit, 1);
      load(0);
      wait_idle();
      poll(120, 50);  check("lzb_zero_ls", Hit, 1);
      poll(100, 50);  check("lzb_zero_ms", Hit, 0);
      LeadZeroBlank = 0;
      ObjectX = 0; ObjectY = 0; ObjectScale = 7;
      poll(447, 287); check("s7_corner_hit2", Hit2, 1); check("s7_corner_hit", Hit, 1);
      poll(448, 0);   check("s7_right_hit2", Hit2, 0);
      poll(0, 288);   check("s7_below_hit2", Hit2, 0);
      ObjectX = 1500; ObjectScale = 0;
      poll(1000, 0);  check("neg_dx_hit2", Hit2, 0);
      ObjectX = 100; ObjectY = 50; ObjectScale = 0;
      poll(113, 58);  check("s0_last_col", Hit, 1);
`ifdef SCORE_BLINK_EN
      ObjectScale = 1;
      poll(100, 50);
      Blink = 1;
      t0 = 0;
      run = 0;
      prev = Hit;
      while (Hit == prev && t0 < 40) begin tick(); t0++; end
      prev = Hit;
      while (Hit == prev && run < 40) begin tick(); run++; end
      check("blink_half_period", run, 16);
      Blink = 0;
      tick(3);
`endif
      tick(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
